rf_arbiter: RTL and testbench
=============================

# rf_arbiter

Shares the single regfile (2 read ports, 1 write port, registered read data, 32 × 32-bit) between NREQ requesters, e.g. the CPU core and a debug/loader port. Each cycle it grants at most one requester, drives that requester's addresses, write enable and write data onto the regfile ports, and returns the regfile read data to that requester one cycle later. Arbitration is round-robin, with an optional bounded lock for back-to-back access by one requester.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..4)
- LOCK_MAX, 4, maximum consecutive grants to one locked requester (≥1)

Ports (clock and reset first; per-requester fields are flattened, requester i occupies slice i):
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has a pending access
- req_lock  in  NREQ  requester i asks to keep the grant next cycle
- req_we  in  NREQ  access includes a write
- req_r1, req_r2  in  5*NREQ  read register numbers
- req_wrn  in  5*NREQ  write register number
- req_wrd  in  32*NREQ  write data
- req_ready  out  NREQ  one-hot grant; a handshake completes when valid && ready
- rsp_valid  out  NREQ  one-hot; read data for requester i is valid this cycle
- rsp_d1, rsp_d2  out  32  shared read data buses
- rf_r1, rf_r2, rf_wrn  out  5  to regfile
- rf_wrd  out  32  to regfile
- rf_we  out  1  to regfile
- rf_out1, rf_out2  in  32  from regfile

## Operation
- Grant is combinational from req_valid, the round-robin pointer and the lock state. At most one bit of req_ready is set. req_ready is never set without the matching req_valid.
- Round-robin: the search starts at pointer `ptr`. After a grant to i, `ptr` ← (i+1) mod NREQ. With no grant, `ptr` holds.
- Lock: if the granted i has req_lock[i]=1 and `lock_cnt` < LOCK_MAX−1, `lock_cnt` increments. Next cycle i wins if req_valid[i], regardless of `ptr`.
  - When `lock_cnt` reaches LOCK_MAX−1, the lock expires and normal round-robin resumes from i+1. This forces a rotation.
  - `lock_cnt` clears on any cycle in which the locked owner is not granted, or on a grant without lock.
- Datapath muxing:
  - With grant to i: rf_r1/rf_r2/rf_wrn/rf_wrd come from slice i, and rf_we = req_we[i].
  - With no grant: all rf_* outputs are 0, including rf_we = 0.
- Response: a 1-bit valid plus a 2-bit id register captures the grant.
  - In the next cycle rsp_valid[id]=1, with rsp_d1=rf_out1 and rsp_d2=rf_out2 passed through combinationally.
  - Every grant produces exactly one response, writes included.
- Read-during-write: a read of the register being written in the same grant returns the old value. This is regfile behaviour; the arbiter does not bypass.
- Requester rule: req_valid and its payload are held stable until accepted. Behaviour under a violation is undefined.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rf_we=0, rf_* addresses and data 0, rsp_d1/rsp_d2 follow rf_out, `ptr`=0, `lock_cnt`=0.
- While rst=1, no grant is issued.
- A rst asserted in the cycle after a grant drops that response: rsp_valid=0.
- Latency: request accepted at edge T (valid && ready during cycle T−1→T) means the regfile latches read data at T, and rsp_valid is high for cycle T→T+1 only.
- Throughput: one access per cycle total. Back-to-back grants to different requesters produce back-to-back responses.
- Fairness: without locks, a continuously valid requester waits at most NREQ−1 cycles. With locks, it waits at most (NREQ−1)·LOCK_MAX cycles.
- Simultaneous valid requesters: the first index at or after `ptr`, cyclically, wins.

## Structure
- Package `rf_pkg`: REG_AW=5, REG_DW=32, NREQ_MAX=4, and a typedef for the request payload struct (we, r1, r2, wrn, wrd).
- Sub-module `rr_pick`: combinational round-robin priority picker (req vector, pointer → one-hot grant, index).
- Top level holds `ptr`, `lock_cnt`, the response valid/id registers and the payload mux.
- The regfile is instantiated beside the arbiter, not inside it.

## Test plan
- Reset: hold rst 3 cycles with all req_valid=1 → req_ready=0, rsp_valid=0, rf_we=0 throughout. The first grant after release goes to requester 0.
- Round-robin: NREQ=2, both valid continuously, no lock → grants alternate 0,1,0,1. Each rsp_valid follows its grant by one cycle with the matching id.
- Write then read: req 0 writes r5=0xDEADBEEF; the next cycle req 1 reads r1=r2=5 → rsp_d1=rsp_d2=0xDEADBEEF, rsp_valid=2'b10. A same-cycle read of r5 in the write access returns the old value.
- Lock bound: LOCK_MAX=4, req 0 locked and always valid, req 1 valid → grants 0,0,0,0,1,0,0,0,0,1.
- Idle and lone requester: only req 1 valid for 5 cycles → granted every cycle. With no requests, rf_we=0 and rsp_valid=0.
- Reset mid-operation: grant to req 0 at cycle T, rst at T+1 → no rsp_valid pulse. After release, `ptr`=0 and `lock_cnt`=0.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and the request payload type for the regfile
// arbiter. REG_AW/REG_DW describe the 32 x 32-bit regfile; IDW is the
// requester index width, sized for NREQ_MAX requesters.
package rf_pkg;
   localparam int REG_AW   = 5;
   localparam int REG_DW   = 32;
   localparam int NREQ_MAX = 4;
   localparam int IDW      = 2;

   typedef struct packed {
      logic              we;
      logic [REG_AW-1:0] r1;
      logic [REG_AW-1:0] r2;
      logic [REG_AW-1:0] wrn;
      logic [REG_DW-1:0] wrd;
   } rf_req_t;
endpackage

// File: rtl/rf_arbiter_if.sv
// rf_arbiter_if: requester, response and regfile-side signals of the arbiter.
// Per-requester fields are flattened; requester i occupies slice i.
//   master : requesters plus the regfile (drive req_*, rf_out*)
//   slave  : the arbiter (drives req_ready, rsp_*, rf_* addresses/data/we)
interface rf_arbiter_if #(parameter int NREQ = 2);
   import rf_pkg::*;

   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_lock;
   logic [NREQ-1:0]        req_we;
   logic [NREQ*REG_AW-1:0] req_r1;
   logic [NREQ*REG_AW-1:0] req_r2;
   logic [NREQ*REG_AW-1:0] req_wrn;
   logic [NREQ*REG_DW-1:0] req_wrd;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        rsp_valid;
   logic [REG_DW-1:0]      rsp_d1;
   logic [REG_DW-1:0]      rsp_d2;
   logic [REG_AW-1:0]      rf_r1;
   logic [REG_AW-1:0]      rf_r2;
   logic [REG_AW-1:0]      rf_wrn;
   logic [REG_DW-1:0]      rf_wrd;
   logic                   rf_we;
   logic [REG_DW-1:0]      rf_out1;
   logic [REG_DW-1:0]      rf_out2;

   modport master (
      output req_valid, req_lock, req_we, req_r1, req_r2, req_wrn, req_wrd,
      output rf_out1, rf_out2,
      input  req_ready, rsp_valid, rsp_d1, rsp_d2,
      input  rf_r1, rf_r2, rf_wrn, rf_wrd, rf_we
   );

   modport slave (
      input  req_valid, req_lock, req_we, req_r1, req_r2, req_wrn, req_wrd,
      input  rf_out1, rf_out2,
      output req_ready, rsp_valid, rsp_d1, rsp_d2,
      output rf_r1, rf_r2, rf_wrn, rf_wrd, rf_we
   );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req : request vector
//   ptr : index where the search starts (< N)
//   gnt : one-hot grant, first set bit at or after ptr, cyclically
//   idx : index of the granted bit (0 when none)
//   any : at least one request present
module rr_pick
   import rf_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] idx,
   output logic           any
);

   int j;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/rf_arbiter.sv
// rf_arbiter: shares one 2R/1W regfile (registered read data) between NREQ
// requesters. Round-robin grant with a bounded lock; the granted requester's
// payload is muxed onto the regfile ports and its read data is flagged back
// one cycle later on the shared rsp_d1/rsp_d2 buses.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rf_arbiter_if slave (requests, responses, regfile ports)
module rf_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ     = 2,
   parameter int LOCK_MAX = 4
) (
   input logic         clk,
   input logic         rst,
   rf_arbiter_if.slave bus
);

   localparam int CW = $clog2(LOCK_MAX + 1);

   logic [IDW-1:0]  ptr, owner, pick_idx, gnt_idx;
   logic [CW-1:0]   lock_cnt, cnt_base;
   logic [NREQ-1:0] pick_gnt, gnt;
   logic            pick_any, gnt_any, gnt_lock, owner_valid, locked;
   logic            rsp_vld_q;
   logic [IDW-1:0]  rsp_id_q;
   rf_req_t         slice [NREQ];
   rf_req_t         sel;

   for (genvar g = 0; g < NREQ; g++) begin : g_slice
      assign slice[g] = '{we:  bus.req_we[g],
                          r1:  bus.req_r1[g*REG_AW +: REG_AW],
                          r2:  bus.req_r2[g*REG_AW +: REG_AW],
                          wrn: bus.req_wrn[g*REG_AW +: REG_AW],
                          wrd: bus.req_wrd[g*REG_DW +: REG_DW]};
   end

   rr_pick #(.N(NREQ)) u_pick (
      .req (bus.req_valid),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // A nonzero count means the last grant went to `owner` with lock held
   // and the bound has not yet been reached.
   assign locked = (lock_cnt != '0);

   always_comb begin
      owner_valid = 1'b0;
      for (int i = 0; i < NREQ; i++)
         if (IDW'(i) == owner) owner_valid = bus.req_valid[i];
   end

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      if (!rst) begin
         if (locked && owner_valid) begin
            gnt_idx = owner;
            gnt_any = 1'b1;
            for (int i = 0; i < NREQ; i++)
               if (IDW'(i) == owner) gnt[i] = 1'b1;
         end else begin
            gnt     = pick_gnt;
            gnt_idx = pick_idx;
            gnt_any = pick_any;
         end
      end
   end

   // Payload mux; sel stays all-zero without a grant, which also drops rf_we.
   always_comb begin
      sel      = '0;
      gnt_lock = 1'b0;
      for (int i = 0; i < NREQ; i++)
         if (gnt[i]) begin
            sel      = slice[i];
            gnt_lock = bus.req_lock[i];
         end
   end

   // A grant to a different requester starts a fresh lock run.
   assign cnt_base = (locked && gnt_idx == owner) ? lock_cnt : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         owner     <= '0;
         lock_cnt  <= '0;
         rsp_vld_q <= 1'b0;
         rsp_id_q  <= '0;
      end else begin
         rsp_vld_q <= gnt_any;
         rsp_id_q  <= gnt_idx;
         if (gnt_any) begin
            ptr   <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
            owner <= gnt_idx;
            if (gnt_lock && cnt_base < CW'(LOCK_MAX-1))
               lock_cnt <= cnt_base + CW'(1);
            else
               lock_cnt <= '0;   // no lock requested, or bound reached
         end else begin
            lock_cnt <= '0;
         end
      end
   end

   assign bus.req_ready = gnt;
   assign bus.rf_r1     = sel.r1;
   assign bus.rf_r2     = sel.r2;
   assign bus.rf_wrn    = sel.wrn;
   assign bus.rf_wrd    = sel.wrd;
   assign bus.rf_we     = sel.we;
   assign bus.rsp_d1    = bus.rf_out1;
   assign bus.rsp_d2    = bus.rf_out2;

   // Gated by rst so a reset in the cycle after a grant drops its response.
   always_comb begin
      bus.rsp_valid = '0;
      for (int i = 0; i < NREQ; i++)
         bus.rsp_valid[i] = rsp_vld_q && !rst && (rsp_id_q == IDW'(i));
   end

endmodule

// File: tb/tb_rf_arbiter.sv
module tb_rf_arbiter;
   import rf_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   rf_arbiter_if #(.NREQ(2)) bus ();

   rf_arbiter #(.NREQ(2), .LOCK_MAX(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Regfile model: registered read, write at the edge, read returns old data.
   logic [31:0] mem [32];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= i * 32'h01010101;
      end else if (bus.rf_we) begin
         mem[bus.rf_wrn] <= bus.rf_wrd;
      end
      bus.rf_out1 <= mem[bus.rf_r1];
      bus.rf_out2 <= mem[bus.rf_r2];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic lk, input logic we,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] wrn, input logic [31:0] wrd);
      bus.req_valid[i]        = v;
      bus.req_lock[i]         = lk;
      bus.req_we[i]           = we;
      bus.req_r1[i*5 +: 5]    = r1;
      bus.req_r2[i*5 +: 5]    = r2;
      bus.req_wrn[i*5 +: 5]   = wrn;
      bus.req_wrd[i*32 +: 32] = wrd;
   endtask

   logic [1:0] rr_exp [4];
   logic [1:0] lk_exp [10];

   initial begin
      rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
      lk_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
      bus.rf_out1 = '0;
      bus.rf_out2 = '0;

      // Reset held 3 cycles with both requesters valid (req 0 writing).
      rst = 1'b1;
      set_req(0, 1, 0, 1, 5'd0, 5'd0, 5'd9, 32'h1);
      set_req(1, 1, 0, 1, 5'd0, 5'd0, 5'd9, 32'h2);
      repeat (3) begin
         @(negedge clk); #1;
         chk("rst_ready", bus.req_ready, 2'b00);
         chk("rst_rsp",   bus.rsp_valid, 2'b00);
         chk("rst_we",    bus.rf_we,     1'b0);
      end

      // Round-robin, no lock: 0,1,0,1 with responses one cycle behind.
      @(negedge clk);
      rst = 1'b0;
      set_req(0, 1, 0, 0, 5'd3, 5'd4, 5'd0, 32'h0);
      set_req(1, 1, 0, 0, 5'd7, 5'd8, 5'd0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk("rr_ready", bus.req_ready, rr_exp[k]);
         chk("rr_rf_r1", bus.rf_r1, (k % 2 == 0) ? 5'd3 : 5'd7);
         chk("rr_rf_r2", bus.rf_r2, (k % 2 == 0) ? 5'd4 : 5'd8);
         if (k == 0) begin
            chk("rr_rsp_first", bus.rsp_valid, 2'b00);
         end else begin
            chk("rr_rsp", bus.rsp_valid, rr_exp[k-1]);
            chk("rr_rsp_d1", bus.rsp_d1, (k % 2 == 1) ? 32'h03030303 : 32'h07070707);
         end
      end

      // Write r5 by req 0 (same-access read of r5), then req 1 reads r5.
      @(negedge clk);
      set_req(0, 1, 0, 1, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF);
      set_req(1, 1, 0, 0, 5'd5, 5'd5, 5'd0, 32'h0);
      #1;
      chk("wr_ready", bus.req_ready, 2'b01);
      chk("wr_we",    bus.rf_we,     1'b1);
      chk("wr_wrn",   bus.rf_wrn,    5'd5);
      chk("wr_wrd",   bus.rf_wrd,    32'hDEADBEEF);
      chk("wr_rsp",   bus.rsp_valid, 2'b10);
      @(negedge clk);
      set_req(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0);
      #1;
      chk("rd_ready",  bus.req_ready, 2'b10);
      chk("rd_we",     bus.rf_we,     1'b0);
      chk("wr_rsp_v",  bus.rsp_valid, 2'b01);
      chk("wr_old_d1", bus.rsp_d1,    32'h05050505);
      chk("wr_old_d2", bus.rsp_d2,    32'h05050505);
      @(negedge clk);
      set_req(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0);
      #1;
      chk("idle_ready", bus.req_ready, 2'b00);
      chk("idle_we",    bus.rf_we,     1'b0);
      chk("rd_rsp_v",   bus.rsp_valid, 2'b10);
      chk("rd_d1",      bus.rsp_d1,    32'hDEADBEEF);
      chk("rd_d2",      bus.rsp_d2,    32'hDEADBEEF);
      @(negedge clk); #1;
      chk("idle_rsp",   bus.rsp_valid, 2'b00);
      chk("idle_we2",   bus.rf_we,     1'b0);
      chk("idle_r1",    bus.rf_r1,     5'd0);

      // Lone requester 1 for 5 cycles.
      set_req(1, 1, 0, 0, 5'd5, 5'd2, 5'd0, 32'h0);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk("lone_ready", bus.req_ready, 2'b10);
         chk("lone_rsp",   bus.rsp_valid, (k == 0) ? 2'b00 : 2'b10);
      end
      @(negedge clk);
      set_req(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0);
      #1;
      chk("lone_tail_rsp",   bus.rsp_valid, 2'b10);
      chk("lone_tail_ready", bus.req_ready, 2'b00);

      // Lock bound: req 0 locked and always valid, req 1 valid.
      @(negedge clk);
      set_req(0, 1, 1, 0, 5'd1, 5'd1, 5'd0, 32'h0);
      set_req(1, 1, 0, 0, 5'd2, 5'd2, 5'd0, 32'h0);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk("lock_ready", bus.req_ready, lk_exp[k]);
      end

      // Reset in the cycle after a locked grant to req 0.
      @(negedge clk); #1;
      chk("mid_grant", bus.req_ready, 2'b01);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rsp_drop", bus.rsp_valid, 2'b00);
      chk("mid_ready",    bus.req_ready, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_ptr",      dut.ptr,       2'd0);
      chk("mid_lock_cnt", dut.lock_cnt,  3'd0);
      chk("mid_rsp_post", bus.rsp_valid, 2'b00);
      chk("mid_regrant",  bus.req_ready, 2'b01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
